alu_dec_unit: RTL and testbench

ALU_DEC_UNIT -- requirements
Module: alu_dec

---
 rtl/alu_dec_unit.sv | 80 ++++++++
 tb/tb_alu_dec_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu_dec_unit.sv
// ALU control decoder: maps alu_op/funct3/funct7/opcode_b5 to an ALU operation code, plus a registered copy.
// Optional macro ALU_DEC_FULL_RV32I_EN adds XOR/SLL/SLTU/SRL/SRA decoding for alu_op=10.
module alu_dec_unit #(
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              opcode_b5,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [1:0]        alu_op,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal,
  output logic [CTRL_W-1:0] alu_ctrl_q,
  output logic              illegal_q
);

  localparam logic [CTRL_W-1:0] ALU_ADD  = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] ALU_SUB  = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] ALU_AND  = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] ALU_OR   = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] ALU_SLT  = CTRL_W'(4);
`ifdef ALU_DEC_FULL_RV32I_EN
  localparam logic [CTRL_W-1:0] ALU_XOR  = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] ALU_SLL  = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] ALU_SRL  = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] ALU_SRA  = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] ALU_SLTU = CTRL_W'(9);
`endif

  // Only funct7[5] carries meaning for the supported encodings.
  logic f7_b5;
  logic unused_funct7;
  assign f7_b5         = funct7[5];
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    unique case (alu_op)
      2'b00: alu_ctrl = ALU_ADD;
      2'b01: alu_ctrl = ALU_SUB;
      2'b10: begin
        case (funct3)
          // ADDI carries an immediate in the funct7 field, so only R-type may subtract.
          3'b000: alu_ctrl = (opcode_b5 && f7_b5) ? ALU_SUB : ALU_ADD;
          3'b111: alu_ctrl = ALU_AND;
          3'b110: alu_ctrl = ALU_OR;
          3'b010: alu_ctrl = ALU_SLT;
`ifdef ALU_DEC_FULL_RV32I_EN
          3'b100: alu_ctrl = ALU_XOR;
          3'b001: alu_ctrl = ALU_SLL;
          3'b011: alu_ctrl = ALU_SLTU;
          3'b101: alu_ctrl = f7_b5 ? ALU_SRA : ALU_SRL;
`endif
          default: begin
            alu_ctrl = ALU_ADD;
            illegal  = 1'b1;
          end
        endcase
      end
      default: begin
        alu_ctrl = ALU_ADD;
        illegal  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctrl_q <= ALU_ADD;
      illegal_q  <= 1'b0;
    end else if (en) begin
      alu_ctrl_q <= alu_ctrl;
      illegal_q  <= illegal;
    end
  end

endmodule

// File: tb/tb_alu_dec_unit.sv
// Directed and random checks of alu_dec_unit, combinational and registered outputs.
module tb_alu_dec_unit;
  localparam int CTRL_W = 4;
  localparam int W = CTRL_W + 1;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              opcode_b5;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [1:0]        alu_op;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              illegal;
  logic [CTRL_W-1:0] alu_ctrl_q;
  logic              illegal_q;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] held;

  alu_dec_unit #(.CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .opcode_b5(opcode_b5),
    .funct3(funct3), .funct7(funct7), .alu_op(alu_op),
    .alu_ctrl(alu_ctrl), .illegal(illegal),
    .alu_ctrl_q(alu_ctrl_q), .illegal_q(illegal_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode written from the operation table; result is {illegal, ctrl}.
  function automatic logic [W-1:0] model(input logic [1:0] op, input logic b5,
                                         input logic [2:0] f3, input logic [6:0] f7);
    logic [W-1:0] r;
    r = {1'b0, 4'd0};
    if (op == 2'b01) r = {1'b0, 4'd1};
    else if (op == 2'b11) r = {1'b1, 4'd0};
    else if (op == 2'b10) begin
      if (f3 == 3'b000) r = {1'b0, (b5 && f7[5]) ? 4'd1 : 4'd0};
      else if (f3 == 3'b111) r = {1'b0, 4'd2};
      else if (f3 == 3'b110) r = {1'b0, 4'd3};
      else if (f3 == 3'b010) r = {1'b0, 4'd4};
`ifdef ALU_DEC_FULL_RV32I_EN
      else if (f3 == 3'b100) r = {1'b0, 4'd5};
      else if (f3 == 3'b001) r = {1'b0, 4'd6};
      else if (f3 == 3'b011) r = {1'b0, 4'd9};
      else if (f3 == 3'b101) r = {1'b0, f7[5] ? 4'd8 : 4'd7};
`endif
      else r = {1'b1, 4'd0};
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic b5, input logic [2:0] f3,
                       input logic [6:0] f7, input logic en_v);
    alu_op = op; opcode_b5 = b5; funct3 = f3; funct7 = f7; en = en_v;
  endtask

  // One cycle: drive at negedge, check combinational result, then check the register after posedge.
  task automatic step(input string tag, input logic [1:0] op, input logic b5,
                      input logic [2:0] f3, input logic [6:0] f7, input logic en_v,
                      input logic [W-1:0] exp);
    @(negedge clk);
    drive(op, b5, f3, f7, en_v);
    #1;
    check({tag, "_comb"}, {illegal, alu_ctrl}, exp);
    if (en_v) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) held = exp_q.pop_front();
    check({tag, "_reg"}, {illegal_q, alu_ctrl_q}, held);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(2'b01, 1'b0, 3'b000, 7'd0, 1'b1);
    held = {1'b0, 4'd0};
    #1;
    check("reset_reg", {illegal_q, alu_ctrl_q}, {1'b0, 4'd0});
    check("reset_comb_unaffected", {illegal, alu_ctrl}, {1'b0, 4'd1});
    @(posedge clk);
    #1;
    check("reset_holds_over_clk", {illegal_q, alu_ctrl_q}, {1'b0, 4'd0});
    @(negedge clk);
    rst_n = 1'b1;

    step("op00_ignores", 2'b00, 1'b0, 3'b111, 7'b0100000, 1'b1, {1'b0, 4'd0});
    step("op01_sub",     2'b01, 1'b0, 3'b110, 7'b0000000, 1'b1, {1'b0, 4'd1});
    step("op11_resv",    2'b11, 1'b1, 3'b000, 7'b0000000, 1'b1, {1'b1, 4'd0});
    step("r_add",        2'b10, 1'b1, 3'b000, 7'b0000000, 1'b1, {1'b0, 4'd0});
    step("r_sub",        2'b10, 1'b1, 3'b000, 7'b0100000, 1'b1, {1'b0, 4'd1});
    step("r_and",        2'b10, 1'b1, 3'b111, 7'b0000000, 1'b1, {1'b0, 4'd2});
    step("r_or",         2'b10, 1'b1, 3'b110, 7'b0000000, 1'b1, {1'b0, 4'd3});
    step("r_slt",        2'b10, 1'b1, 3'b010, 7'b0000000, 1'b1, {1'b0, 4'd4});
    step("addi_not_sub", 2'b10, 1'b0, 3'b000, 7'b0100000, 1'b1, {1'b0, 4'd0});
`ifdef ALU_DEC_FULL_RV32I_EN
    step("r_sra",        2'b10, 1'b1, 3'b101, 7'b0100000, 1'b1, {1'b0, 4'd8});
    step("i_srl",        2'b10, 1'b0, 3'b101, 7'b0000000, 1'b1, {1'b0, 4'd7});
    step("i_xor",        2'b10, 1'b0, 3'b100, 7'b0000000, 1'b1, {1'b0, 4'd5});
    step("r_sll",        2'b10, 1'b1, 3'b001, 7'b0000000, 1'b1, {1'b0, 4'd6});
    step("r_sltu",       2'b10, 1'b1, 3'b011, 7'b0000000, 1'b1, {1'b0, 4'd9});
`else
    step("f3_101_undec", 2'b10, 1'b1, 3'b101, 7'b0100000, 1'b1, {1'b1, 4'd0});
    step("f3_100_undec", 2'b10, 1'b0, 3'b100, 7'b0000000, 1'b1, {1'b1, 4'd0});
    step("f3_001_undec", 2'b10, 1'b1, 3'b001, 7'b0000000, 1'b1, {1'b1, 4'd0});
    step("f3_011_undec", 2'b10, 1'b1, 3'b011, 7'b0000000, 1'b1, {1'b1, 4'd0});
`endif

    // Load SUB, then hold it with en low while inputs change.
    step("load_sub",     2'b01, 1'b0, 3'b000, 7'b0000000, 1'b1, {1'b0, 4'd1});
    step("hold_en0_a",   2'b11, 1'b0, 3'b000, 7'b0000000, 1'b0, {1'b1, 4'd0});
    step("hold_en0_b",   2'b10, 1'b1, 3'b111, 7'b0000000, 1'b0, {1'b0, 4'd2});

    // Reset pulse between clocks clears the register immediately.
    @(negedge clk);
    drive(2'b01, 1'b0, 3'b000, 7'd0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_pulse_reg", {illegal_q, alu_ctrl_q}, {1'b0, 4'd0});
    check("rst_pulse_comb", {illegal, alu_ctrl}, {1'b0, 4'd1});
    exp_q.delete();
    held = {1'b0, 4'd0};
    #1;
    rst_n = 1'b1;
    step("resume_after_rst", 2'b11, 1'b0, 3'b010, 7'b0000000, 1'b1, {1'b1, 4'd0});

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic       b5;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       e;
      op = 2'($urandom_range(0, 3));
      b5 = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      f7 = 7'($urandom_range(0, 127));
      e  = ($urandom_range(0, 3) != 0);
      step("random", op, b5, f3, f7, e, model(op, b5, f3, f7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
